// File: rtl/operand_forward_stage.sv
// operand_forward_stage: ID/EX stage that resolves RAW hazards by forwarding
// from EX/MEM/WB, bubbles on load-use, and registers operands for EX.
// Optional statistics counters are enabled by defining OPERAND_FWD_STATS_EN.
module operand_forward_stage #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_ra,
   input  logic [REG_AW-1:0] id_rb,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_uses_a,
   input  logic              id_uses_b,
   input  logic              id_writes,
   input  logic              id_is_load,
   input  logic [DATA_W-1:0] rf_bus_a,
   input  logic [DATA_W-1:0] rf_bus_b,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_writes,
   input  logic [DATA_W-1:0] mem_result,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_enable,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              hold_in,
   input  logic              flush,
   output logic              id_stall,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_op_a,
   output logic [DATA_W-1:0] ex_op_b,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_writes,
   output logic              ex_is_load
`ifdef OPERAND_FWD_STATS_EN
   ,
   output logic [15:0]       fwd_count,
   output logic [15:0]       stall_count
`endif
);

   localparam int unsigned CNT_W = 16;

   logic              ex_valid_q,   ex_valid_d;
   logic [DATA_W-1:0] ex_op_a_q,    ex_op_a_d;
   logic [DATA_W-1:0] ex_op_b_q,    ex_op_b_d;
   logic [REG_AW-1:0] ex_rd_q,      ex_rd_d;
   logic              ex_writes_q,  ex_writes_d;
   logic              ex_is_load_q, ex_is_load_d;

   logic              load_use_c;
   logic [DATA_W-1:0] sel_a_c;
   logic [DATA_W-1:0] sel_b_c;

   // Youngest-producer-first operand resolution; R0 always reads as zero.
   function automatic logic [DATA_W-1:0] pick_operand(
      input logic [REG_AW-1:0] src,
      input logic              used,
      input logic [DATA_W-1:0] rf_val
   );
      logic live;
      live = id_valid && used && (src != '0);
      if (src == '0)
         pick_operand = '0;
      else if (live && ex_valid_q && ex_writes_q && !ex_is_load_q && (ex_rd_q == src))
         pick_operand = ex_alu_result;
      else if (live && mem_writes && (mem_rd == src))
         pick_operand = mem_result;
      else if (live && wb_enable && (wb_rd == src))
         pick_operand = wb_data;
      else
         pick_operand = rf_val;
   endfunction

   // Operand selection and load-use hazard detection.
   always_comb begin
      sel_a_c    = pick_operand(id_ra, id_uses_a, rf_bus_a);
      sel_b_c    = pick_operand(id_rb, id_uses_b, rf_bus_b);
      load_use_c = ex_valid_q && ex_is_load_q && ex_writes_q && (ex_rd_q != '0) &&
                   id_valid && ((id_uses_a && (id_ra == ex_rd_q)) ||
                                (id_uses_b && (id_rb == ex_rd_q)));
      id_stall   = reset_n && (load_use_c || hold_in);
   end

   // Next-state for the EX slot: flush > hold > bubble > capture.
   always_comb begin
      ex_valid_d   = ex_valid_q;
      ex_op_a_d    = ex_op_a_q;
      ex_op_b_d    = ex_op_b_q;
      ex_rd_d      = ex_rd_q;
      ex_writes_d  = ex_writes_q;
      ex_is_load_d = ex_is_load_q;
      if (flush || (!hold_in && load_use_c)) begin
         ex_valid_d   = 1'b0;
         ex_writes_d  = 1'b0;
         ex_is_load_d = 1'b0;
      end else if (!hold_in) begin
         ex_valid_d   = id_valid;
         ex_op_a_d    = sel_a_c;
         ex_op_b_d    = sel_b_c;
         ex_rd_d      = id_valid ? id_rd : '0;
         ex_writes_d  = id_valid && id_writes;
         ex_is_load_d = id_valid && id_is_load;
      end
   end

   // EX slot registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ex_valid_q   <= 1'b0;
         ex_op_a_q    <= '0;
         ex_op_b_q    <= '0;
         ex_rd_q      <= '0;
         ex_writes_q  <= 1'b0;
         ex_is_load_q <= 1'b0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_op_a_q    <= ex_op_a_d;
         ex_op_b_q    <= ex_op_b_d;
         ex_rd_q      <= ex_rd_d;
         ex_writes_q  <= ex_writes_d;
         ex_is_load_q <= ex_is_load_d;
      end
   end

   assign ex_valid   = ex_valid_q;
   assign ex_op_a    = ex_op_a_q;
   assign ex_op_b    = ex_op_b_q;
   assign ex_rd      = ex_rd_q;
   assign ex_writes  = ex_writes_q;
   assign ex_is_load = ex_is_load_q;

`ifdef OPERAND_FWD_STATS_EN
   logic [CNT_W-1:0] fwd_count_q,   fwd_count_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             fwd_any_c;

   // True when a used, non-zero source is served by EX, MEM or WB.
   function automatic logic is_forwarded(
      input logic [REG_AW-1:0] src,
      input logic              used
   );
      logic live;
      live = id_valid && used && (src != '0);
      is_forwarded = live && ((ex_valid_q && ex_writes_q && !ex_is_load_q && (ex_rd_q == src)) ||
                              (mem_writes && (mem_rd == src)) ||
                              (wb_enable && (wb_rd == src)));
   endfunction

   // Saturating statistics, frozen during hold and flush.
   always_comb begin
      fwd_count_d   = fwd_count_q;
      stall_count_d = stall_count_q;
      fwd_any_c     = is_forwarded(id_ra, id_uses_a) || is_forwarded(id_rb, id_uses_b);
      if (!flush && !hold_in) begin
         if (load_use_c) begin
            if (stall_count_q != {CNT_W{1'b1}})
               stall_count_d = stall_count_q + CNT_W'(1);
         end else if (id_valid && fwd_any_c) begin
            if (fwd_count_q != {CNT_W{1'b1}})
               fwd_count_d = fwd_count_q + CNT_W'(1);
         end
      end
   end

   // Statistics registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fwd_count_q   <= '0;
         stall_count_q <= '0;
      end else begin
         fwd_count_q   <= fwd_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign fwd_count   = fwd_count_q;
   assign stall_count = stall_count_q;
`else
   localparam int unsigned UNUSED_CNT_W = CNT_W;
`endif

endmodule

// File: tb/tb_operand_forward_stage.sv
// Self-checking bench for operand_forward_stage: directed scenarios plus a
// randomized run against a behavioural model of the ID/EX slot.
module tb_operand_forward_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        id_valid;
   logic [2:0]  id_ra, id_rb, id_rd;
   logic        id_uses_a, id_uses_b, id_writes, id_is_load;
   logic [15:0] rf_bus_a, rf_bus_b, ex_alu_result;
   logic [2:0]  mem_rd;
   logic        mem_writes;
   logic [15:0] mem_result;
   logic [2:0]  wb_rd;
   logic        wb_enable;
   logic [15:0] wb_data;
   logic        hold_in, flush;
   logic        id_stall, ex_valid, ex_writes, ex_is_load;
   logic [15:0] ex_op_a, ex_op_b;
   logic [2:0]  ex_rd;

   int errors = 0;
   int checks = 0;

   // Model of the EX slot contents
   logic        m_valid, m_writes, m_is_load;
   logic [2:0]  m_rd;
   logic [15:0] m_a, m_b;

   operand_forward_stage dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
      .id_ra(id_ra), .id_rb(id_rb), .id_rd(id_rd),
      .id_uses_a(id_uses_a), .id_uses_b(id_uses_b),
      .id_writes(id_writes), .id_is_load(id_is_load),
      .rf_bus_a(rf_bus_a), .rf_bus_b(rf_bus_b), .ex_alu_result(ex_alu_result),
      .mem_rd(mem_rd), .mem_writes(mem_writes), .mem_result(mem_result),
      .wb_rd(wb_rd), .wb_enable(wb_enable), .wb_data(wb_data),
      .hold_in(hold_in), .flush(flush), .id_stall(id_stall),
      .ex_valid(ex_valid), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
      .ex_rd(ex_rd), .ex_writes(ex_writes), .ex_is_load(ex_is_load)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_valid = 0; id_ra = 0; id_rb = 0; id_rd = 0;
      id_uses_a = 0; id_uses_b = 0; id_writes = 0; id_is_load = 0;
      rf_bus_a = 0; rf_bus_b = 0; ex_alu_result = 0;
      mem_rd = 0; mem_writes = 0; mem_result = 0;
      wb_rd = 0; wb_enable = 0; wb_data = 0;
      hold_in = 0; flush = 0;
   endtask

   // Value a used source register should see: zero for R0, else the
   // youngest in-flight producer of that register, else the register file.
   function automatic logic [15:0] resolve(input logic [2:0] r, input logic used,
                                           input logic [15:0] rf);
      logic [2:0]  prd [3];
      logic        pw  [3];
      logic [15:0] pv  [3];
      prd[0] = m_rd;   pw[0] = m_valid && m_writes && !m_is_load; pv[0] = ex_alu_result;
      prd[1] = mem_rd; pw[1] = mem_writes;                        pv[1] = mem_result;
      prd[2] = wb_rd;  pw[2] = wb_enable;                         pv[2] = wb_data;
      if (r == 3'd0) return 16'h0000;
      if (!(id_valid && used)) return rf;
      for (int k = 0; k < 3; k++)
         if (pw[k] && prd[k] == r) return pv[k];
      return rf;
   endfunction

   task automatic test_reset();
      clear_inputs();
      reset_n = 0; id_valid = 1; id_writes = 1; id_rd = 3'd3; hold_in = 1;
      rf_bus_a = 16'hBEEF; rf_bus_b = 16'hCAFE;
      step(); step();
      checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL reset_id_stall got=%b exp=0", id_stall); end
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
      checks++; if (ex_op_a !== 16'h0) begin errors++; $display("FAIL reset_ex_op_a got=%h exp=0000", ex_op_a); end
      checks++; if (ex_op_b !== 16'h0) begin errors++; $display("FAIL reset_ex_op_b got=%h exp=0000", ex_op_b); end
      checks++; if (ex_rd !== 3'd0) begin errors++; $display("FAIL reset_ex_rd got=%0d exp=0", ex_rd); end
      checks++; if (ex_writes !== 1'b0) begin errors++; $display("FAIL reset_ex_writes got=%b exp=0", ex_writes); end
      checks++; if (ex_is_load !== 1'b0) begin errors++; $display("FAIL reset_ex_is_load got=%b exp=0", ex_is_load); end
      clear_inputs();
      reset_n = 1;
      step();
   endtask

   task automatic test_alu_back_to_back();
      clear_inputs();
      id_valid = 1; id_rd = 3'd3; id_writes = 1;
      step();
      id_rd = 3'd5; id_ra = 3'd3; id_uses_a = 1; rf_bus_a = 16'h0000; ex_alu_result = 16'h0005;
      #1;
      checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL alu_b2b_stall got=%b exp=0", id_stall); end
      step();
      checks++; if (ex_op_a !== 16'h0005) begin errors++; $display("FAIL alu_b2b_op_a got=%h exp=0005", ex_op_a); end
      checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL alu_b2b_valid got=%b exp=1", ex_valid); end
   endtask

   task automatic test_priority();
      clear_inputs();
      id_valid = 1; id_rd = 3'd2; id_writes = 1;
      step();
      ex_alu_result = 16'h1111;
      mem_rd = 3'd2; mem_writes = 1; mem_result = 16'h2222;
      wb_rd = 3'd2; wb_enable = 1; wb_data = 16'h3333;
      id_rb = 3'd2; id_uses_b = 1; rf_bus_b = 16'hAAAA; id_rd = 3'd6;
      step();
      checks++; if (ex_op_b !== 16'h1111) begin errors++; $display("FAIL prio_ex got=%h exp=1111", ex_op_b); end
      step();
      checks++; if (ex_op_b !== 16'h2222) begin errors++; $display("FAIL prio_mem got=%h exp=2222", ex_op_b); end
      mem_writes = 0;
      step();
      checks++; if (ex_op_b !== 16'h3333) begin errors++; $display("FAIL prio_wb got=%h exp=3333", ex_op_b); end
   endtask

   task automatic test_load_use();
      clear_inputs();
      id_valid = 1; id_rd = 3'd4; id_writes = 1; id_is_load = 1;
      step();
      checks++; if (ex_is_load !== 1'b1) begin errors++; $display("FAIL lu_load_held got=%b exp=1", ex_is_load); end
      clear_inputs();
      id_valid = 1; id_ra = 3'd4; id_uses_a = 1; id_rd = 3'd1; id_writes = 1;
      #1;
      checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", id_stall); end
      step();
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got=%b exp=0", ex_valid); end
      checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_released got=%b exp=0", id_stall); end
      mem_rd = 3'd4; mem_writes = 1; mem_result = 16'h00AB;
      step();
      checks++; if (ex_op_a !== 16'h00AB) begin errors++; $display("FAIL lu_mem_fwd got=%h exp=00ab", ex_op_a); end
      checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL lu_valid_after got=%b exp=1", ex_valid); end
   endtask

   task automatic test_r0();
      clear_inputs();
      id_valid = 1; id_ra = 3'd0; id_uses_a = 1; rf_bus_a = 16'h1234;
      wb_rd = 3'd0; wb_enable = 1; wb_data = 16'hFFFF;
      step();
      checks++; if (ex_op_a !== 16'h0000) begin errors++; $display("FAIL r0_op_a got=%h exp=0000", ex_op_a); end
   endtask

   task automatic test_hold_flush();
      clear_inputs();
      id_valid = 1; id_rd = 3'd7; id_writes = 1; id_ra = 3'd5; id_uses_a = 1; rf_bus_a = 16'h5A5A;
      step();
      checks++; if (ex_op_a !== 16'h5A5A) begin errors++; $display("FAIL hf_capture got=%h exp=5a5a", ex_op_a); end
      hold_in = 1; id_rd = 3'd2; rf_bus_a = 16'h0F0F;
      #1;
      checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL hf_hold_stall got=%b exp=1", id_stall); end
      for (int c = 0; c < 3; c++) begin
         step();
         checks++; if (ex_op_a !== 16'h5A5A) begin errors++; $display("FAIL hf_hold_op_a cyc=%0d got=%h exp=5a5a", c, ex_op_a); end
         checks++; if (ex_rd !== 3'd7) begin errors++; $display("FAIL hf_hold_rd cyc=%0d got=%0d exp=7", c, ex_rd); end
         checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL hf_hold_valid cyc=%0d got=%b exp=1", c, ex_valid); end
      end
      flush = 1;
      step();
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL hf_flush_valid got=%b exp=0", ex_valid); end
      checks++; if (ex_writes !== 1'b0) begin errors++; $display("FAIL hf_flush_writes got=%b exp=0", ex_writes); end
      clear_inputs();
      step();
   endtask

   task automatic test_random();
      logic        lu, exp_stall, nv, nw, nl;
      logic [2:0]  nrd;
      logic [15:0] na, nb;
      clear_inputs();
      reset_n = 0;
      step();
      reset_n = 1;
      m_valid = 0; m_writes = 0; m_is_load = 0; m_rd = 0; m_a = 0; m_b = 0;
      for (int i = 0; i < 600; i++) begin
         reset_n       = ($urandom_range(0, 49) != 0);
         id_valid      = ($urandom_range(0, 4) != 0);
         id_ra         = 3'($urandom_range(0, 7));
         id_rb         = 3'($urandom_range(0, 7));
         id_rd         = 3'($urandom_range(0, 7));
         id_uses_a     = $urandom_range(0, 1) == 1;
         id_uses_b     = $urandom_range(0, 1) == 1;
         id_writes     = ($urandom_range(0, 3) != 0);
         id_is_load    = ($urandom_range(0, 2) == 0);
         rf_bus_a      = 16'($urandom);
         rf_bus_b      = 16'($urandom);
         ex_alu_result = 16'($urandom);
         mem_rd        = 3'($urandom_range(0, 7));
         mem_writes    = $urandom_range(0, 1) == 1;
         mem_result    = 16'($urandom);
         wb_rd         = 3'($urandom_range(0, 7));
         wb_enable     = $urandom_range(0, 1) == 1;
         wb_data       = 16'($urandom);
         hold_in       = ($urandom_range(0, 7) == 0);
         flush         = ($urandom_range(0, 9) == 0);
         #1;
         lu = m_valid && m_is_load && m_writes && (m_rd != 0) && id_valid &&
              ((id_uses_a && id_ra == m_rd) || (id_uses_b && id_rb == m_rd));
         exp_stall = reset_n && (lu || hold_in);
         checks++; if (id_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, id_stall, exp_stall); end
         na = resolve(id_ra, id_uses_a, rf_bus_a);
         nb = resolve(id_rb, id_uses_b, rf_bus_b);
         nv = m_valid; nw = m_writes; nl = m_is_load; nrd = m_rd;
         if (!reset_n) begin
            nv = 0; nw = 0; nl = 0; nrd = 0; na = 0; nb = 0;
         end else if (flush || (!hold_in && lu)) begin
            nv = 0; nw = 0; nl = 0; na = m_a; nb = m_b;
         end else if (hold_in) begin
            na = m_a; nb = m_b;
         end else begin
            nv = id_valid; nw = id_valid && id_writes; nl = id_valid && id_is_load;
            nrd = id_valid ? id_rd : 3'd0;
         end
         m_valid = nv; m_writes = nw; m_is_load = nl; m_rd = nrd; m_a = na; m_b = nb;
         step();
         checks++; if (ex_valid !== m_valid) begin errors++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, ex_valid, m_valid); end
         checks++; if (ex_writes !== m_writes) begin errors++; $display("FAIL rnd_writes i=%0d got=%b exp=%b", i, ex_writes, m_writes); end
         checks++; if (ex_is_load !== m_is_load) begin errors++; $display("FAIL rnd_is_load i=%0d got=%b exp=%b", i, ex_is_load, m_is_load); end
         if (m_valid) begin
            checks++; if (ex_rd !== m_rd) begin errors++; $display("FAIL rnd_rd i=%0d got=%0d exp=%0d", i, ex_rd, m_rd); end
            checks++; if (ex_op_a !== m_a) begin errors++; $display("FAIL rnd_op_a i=%0d got=%h exp=%h", i, ex_op_a, m_a); end
            checks++; if (ex_op_b !== m_b) begin errors++; $display("FAIL rnd_op_b i=%0d got=%h exp=%h", i, ex_op_b, m_b); end
         end
      end
   endtask

   initial begin
      clear_inputs();
      reset_n = 0;
      test_reset();
      test_alu_back_to_back();
      test_priority();
      test_load_use();
      test_r0();
      test_hold_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
